// File: rtl/conn_check_gen.sv
// conn_check_gen: N_CH square-wave connector generator with loopback checking.
// Optional stuck-level tracking is built when CONN_CHK_STUCK_EN is defined.
module conn_check_gen #(
    parameter int N_CH   = 8,
    parameter int BASE_T = 250000,
    parameter int CNT_W  = 24,
    parameter int GUARD  = 16,
    parameter int ERR_W  = 8,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [N_CH-1:0]  loop_in,
    input  logic [SEL_W-1:0] err_sel,
    output logic [N_CH-1:0]  drive_out,
    output logic [N_CH-1:0]  ch_fail,
    output logic [ERR_W-1:0] err_cnt_sel,
    output logic             checked,
    output logic [N_CH-1:0]  stuck_hi,
    output logic [N_CH-1:0]  stuck_lo
);

    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    logic [N_CH-1:0]  sync_a;
    logic [N_CH-1:0]  sync_b;
    logic             run_q;
    logic [ERR_W-1:0] err_q [N_CH];
    logic [N_CH-1:0]  eval_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            run_q  <= 1'b0;
        end else begin
            sync_a <= loop_in;
            sync_b <= sync_a;
            run_q  <= enable;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int T = BASE_T * (i + 1);
        localparam logic [CNT_W-1:0] LAST = CNT_W'(T - 1);
        localparam logic [CNT_W-1:0] HALF = CNT_W'(T / 2);

        logic [CNT_W-1:0] phase;
        logic [GW-1:0]    guard;
        logic [ERR_W-1:0] err;
        logic [1:0]       evals;
        logic             drv;
        logic             fail;
        logic             bad_q;
        logic             drv_nxt;
        logic             win_end;
        logic             cmp;
        logic             bad_now;

        assign drv_nxt = phase < HALF;
        // run_q excludes the idle cycle before the first high half-period
        assign win_end = enable && run_q && (drv_nxt != drv);
        assign cmp     = enable && run_q && (guard == '0);
        assign bad_now = bad_q || (cmp && (sync_b[i] != drv));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                phase <= '0;
                drv   <= 1'b0;
                guard <= '0;
            end else if (!enable) begin
                phase <= '0;
                drv   <= 1'b0;
                guard <= GW'(GUARD);
            end else begin
                phase <= (phase == LAST) ? '0 : phase + 1'b1;
                drv   <= drv_nxt;
                if (drv_nxt != drv)
                    guard <= GW'(GUARD);
                else if (guard != '0)
                    guard <= guard - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                bad_q <= 1'b0;
                err   <= '0;
                fail  <= 1'b0;
                evals <= '0;
            end else if (clear) begin
                bad_q <= 1'b0;
                err   <= '0;
                fail  <= 1'b0;
                evals <= '0;
            end else if (!enable || !run_q) begin
                bad_q <= 1'b0;
                if (!enable)
                    evals <= '0;
            end else if (win_end) begin
                bad_q <= 1'b0;
                if (evals != 2'd2)
                    evals <= evals + 1'b1;
                if (bad_now) begin
                    fail <= 1'b1;
                    if (err != '1)
                        err <= err + 1'b1;
                end
            end else begin
                bad_q <= bad_now;
            end
        end

`ifdef CONN_CHK_STUCK_EN
        logic all_hi;
        logic all_lo;
        logic hi_now;
        logic lo_now;
        logic s_hi;
        logic s_lo;

        assign hi_now = all_hi && !(cmp && !sync_b[i]);
        assign lo_now = all_lo && !(cmp && sync_b[i]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                all_hi <= 1'b1;
                all_lo <= 1'b1;
                s_hi   <= 1'b0;
                s_lo   <= 1'b0;
            end else begin
                if (clear) begin
                    s_hi <= 1'b0;
                    s_lo <= 1'b0;
                end else if (win_end && bad_now) begin
                    if (hi_now)
                        s_hi <= 1'b1;
                    if (lo_now)
                        s_lo <= 1'b1;
                end
                if (clear || !enable || !run_q || win_end) begin
                    all_hi <= 1'b1;
                    all_lo <= 1'b1;
                end else begin
                    all_hi <= hi_now;
                    all_lo <= lo_now;
                end
            end
        end

        assign stuck_hi[i] = s_hi;
        assign stuck_lo[i] = s_lo;
`else
        assign stuck_hi[i] = 1'b0;
        assign stuck_lo[i] = 1'b0;
`endif

        assign drive_out[i] = drv;
        assign ch_fail[i]   = fail;
        assign err_q[i]     = err;
        // evals saturates at 2, so bit 1 marks "two windows seen"
        assign eval_ok[i]   = evals[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_sel <= '0;
            checked     <= 1'b0;
        end else begin
            err_cnt_sel <= (int'(err_sel) < N_CH) ? err_q[err_sel] : '0;
            checked     <= (!enable || clear) ? 1'b0 : &eval_ok;
        end
    end

endmodule

// File: tb/tb_conn_check_gen.sv
// tb_conn_check_gen: randomized loopback bench for conn_check_gen.
// Reference model works from cycle counts and half-period arithmetic.
`timescale 1ns/1ps
module tb_conn_check_gen;

    localparam int N    = 4;
    localparam int BT   = 40;
    localparam int G    = 4;
    localparam int EW   = 8;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic          clear   = 1'b0;
    logic [N-1:0]  loop_in = '0;
    logic [1:0]    err_sel = '0;
    logic [N-1:0]  drive_out;
    logic [N-1:0]  ch_fail;
    logic [N-1:0]  stuck_hi;
    logic [N-1:0]  stuck_lo;
    logic [EW-1:0] err_cnt_sel;
    logic          checked;

    conn_check_gen #(
        .N_CH(N), .BASE_T(BT), .CNT_W(24), .GUARD(G), .ERR_W(EW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .loop_in(loop_in), .err_sel(err_sel), .drive_out(drive_out),
        .ch_fail(ch_fail), .err_cnt_sel(err_cnt_sel), .checked(checked),
        .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // model state, valid for the current cycle
    int           m_n;
    logic [N-1:0] m_s1, m_s2, m_fail, m_shi, m_slo, m_ahi, m_alo, m_bad;
    logic [N-1:0] prev_drv;
    int           m_err [N];
    int           m_eval [N];
    logic         m_chk;
    int           m_sel;

    // fault injection controls
    logic [N-1:0] hold_en, hold_val, inv;
    int           noise;
    int           g_lo, g_hi;

    function automatic int per(int i);
        return BT * (i + 1);
    endfunction

    function automatic logic exp_drv(int i, int n);
        if (n == 0) return 1'b0;
        return ((n - 1) % per(i)) < (per(i) / 2);
    endfunction

    function automatic int wpos(int i, int n);
        int p;
        p = (n - 1) % per(i);
        return (p < per(i) / 2) ? p : p - per(i) / 2;
    endfunction

    function automatic int wlen(int i, int n);
        int p;
        p = (n - 1) % per(i);
        return (p < per(i) / 2) ? per(i) / 2 : per(i) - per(i) / 2;
    endfunction

    function automatic logic [N-1:0] drv_vec(int n);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = exp_drv(i, n);
        return v;
    endfunction

    task automatic model_reset();
        m_n = 0; m_s1 = '0; m_s2 = '0; m_fail = '0; m_shi = '0; m_slo = '0;
        m_ahi = '1; m_alo = '1; m_bad = '0; prev_drv = '0;
        m_chk = 1'b0; m_sel = 0;
        for (int i = 0; i < N; i++) begin
            m_err[i] = 0;
            m_eval[i] = 0;
        end
    endtask

    task automatic model_step();
        logic all2;
        int   nsel;
        all2 = 1'b1;
        for (int i = 0; i < N; i++) if (m_eval[i] < 2) all2 = 1'b0;
        nsel = m_err[err_sel];
        for (int i = 0; i < N; i++) begin
            logic d, cmp, be, ah, al;
            d = exp_drv(i, m_n);
            if (enable && m_n > 0) begin
                cmp = wpos(i, m_n) >= G;
                be  = m_bad[i] || (cmp && (m_s2[i] != d));
                ah  = m_ahi[i] && !(cmp && !m_s2[i]);
                al  = m_alo[i] && !(cmp && m_s2[i]);
                if (wpos(i, m_n) == wlen(i, m_n) - 1) begin
                    if (be) begin
                        if (m_err[i] < EMAX) m_err[i]++;
                        m_fail[i] = 1'b1;
                        if (ah) m_shi[i] = 1'b1;
                        if (al) m_slo[i] = 1'b1;
                    end
                    if (m_eval[i] < 2) m_eval[i]++;
                    m_bad[i] = 1'b0; m_ahi[i] = 1'b1; m_alo[i] = 1'b1;
                end else begin
                    m_bad[i] = be; m_ahi[i] = ah; m_alo[i] = al;
                end
            end else begin
                m_bad[i] = 1'b0; m_ahi[i] = 1'b1; m_alo[i] = 1'b1;
                if (!enable) m_eval[i] = 0;
            end
            if (clear) begin
                m_err[i] = 0; m_fail[i] = 1'b0; m_eval[i] = 0; m_bad[i] = 1'b0;
                m_shi[i] = 1'b0; m_slo[i] = 1'b0; m_ahi[i] = 1'b1; m_alo[i] = 1'b1;
            end
        end
        m_chk = enable && !clear && all2;
        m_sel = nsel;
        m_n   = enable ? m_n + 1 : 0;
        m_s2  = m_s1;
        m_s1  = loop_in;
    endtask

    task automatic check_all();
        logic [N-1:0] e_hi, e_lo;
`ifdef CONN_CHK_STUCK_EN
        e_hi = m_shi;
        e_lo = m_slo;
`else
        e_hi = '0;
        e_lo = '0;
`endif
        check("drive_out", drive_out, drv_vec(m_n));
        check("ch_fail", ch_fail, m_fail);
        check("err_cnt_sel", err_cnt_sel, m_sel);
        check("checked", checked, m_chk);
        check("stuck_hi", stuck_hi, e_hi);
        check("stuck_lo", stuck_lo, e_lo);
    endtask

    // called at a negedge with enable/clear/err_sel already set
    task automatic cycle();
        logic [N-1:0] v;
        v = prev_drv;
        for (int i = 0; i < N; i++) begin
            if (hold_en[i]) v[i] = hold_val[i];
            if (inv[i]) v[i] = ~v[i];
            if (noise > 0 && $urandom_range(noise - 1, 0) == 0) v[i] = ~v[i];
        end
        if (m_n + 2 >= g_lo && m_n + 2 <= g_hi) v[0] = ~v[0];
        loop_in  = v;
        prev_drv = drv_vec(m_n);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int k);
        for (int j = 0; j < k; j++) cycle();
    endtask

    task automatic restart(input logic [1:0] sel);
        enable = 1'b0; run(2);
        clear = 1'b1; run(1);
        clear = 1'b0; err_sel = sel; enable = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int lim;
        hold_en = '0; hold_val = '0; inv = '0; noise = 0;
        g_lo = -10; g_hi = -10;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check("rst_drive", drive_out, 0);
        check("rst_err", err_cnt_sel, 0);

        // clean loopback from reset
        reset_n = 1'b1;
        enable  = 1'b1;
        while (m_n < 161) cycle();
        check("checked_early", checked, 0);
        cycle();
        check("checked_set", checked, 1);
        run(40);
        check("clean_fail", ch_fail, 0);

        // ch1 pin held low: each high window is bad
        restart(2'd1);
        hold_en = 4'b0010; hold_val = '0;
        run(242);
        check("ch1_err", err_cnt_sel, 3);
        check("ch1_fail", ch_fail, 4'b0010);
`ifdef CONN_CHK_STUCK_EN
        check("ch1_stuck_lo", stuck_lo, 4'b0010);
`endif
        hold_en = '0;

        // 3-cycle glitch on ch0: inside guard, then mid-window
        restart(2'd0);
        run(5);
        n0 = ((m_n - 1) / 20 + 2) * 20 + 1;
        g_lo = n0 + 1; g_hi = n0 + 3;
        while (m_n <= n0 + 30) cycle();
        check("glitch_guard", err_cnt_sel, 0);
        n0 = ((m_n - 1) / 20 + 2) * 20 + 1;
        g_lo = n0 + 10; g_hi = n0 + 12;
        while (m_n <= n0 + 30) cycle();
        check("glitch_window", err_cnt_sel, 1);
        g_lo = -10; g_hi = -10;

        // ch2 inverted for 300 windows, then clear on an increment edge
        restart(2'd2);
        inv = 4'b0100;
        run(300 * 60 + 10);
        check("sat_err", err_cnt_sel, EMAX);
        check("sat_fail", ch_fail[2], 1);
        lim = 0;
        while (wpos(2, m_n) != wlen(2, m_n) - 1 && lim < 100) begin
            cycle();
            lim++;
        end
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clr_fail", ch_fail, 0);
        check("clr_checked", checked, 0);
        cycle();
        check("clr_err", err_cnt_sel, 0);
        inv = '0;

        // enable drop mid-period and restart in phase
        run(37);
        enable = 1'b0; cycle();
        check("drop_drive", drive_out, 0);
        run(5);
        enable = 1'b1; cycle();
        check("reenable_drive", drive_out, 4'hF);
        run(30);

        // randomized enable/clear/noise/hold
        for (int k = 0; k < 4000; k++) begin
            if (enable) begin
                if ($urandom_range(199, 0) == 0) enable = 1'b0;
            end else if ($urandom_range(9, 0) == 0) begin
                enable = 1'b1;
            end
            clear = ($urandom_range(149, 0) == 0);
            if (k % 17 == 0) err_sel = 2'($urandom_range(3, 0));
            if (k % 500 == 0) begin
                noise    = $urandom_range(3, 1) * 40;
                hold_en  = 4'($urandom_range(15, 0) & $urandom_range(15, 0));
                hold_val = 4'($urandom_range(15, 0));
            end
            cycle();
        end
        clear = 1'b0; noise = 0; hold_en = '0;

        // async reset mid-window with errors present
        enable = 1'b1; err_sel = 2'd3; inv = 4'b1000;
        run(200);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_drive", drive_out, 0);
        check("arst_fail", ch_fail, 0);
        check("arst_err", err_cnt_sel, 0);
        check("arst_checked", checked, 0);
        check("arst_stuck", {stuck_hi, stuck_lo}, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        inv = '0;
        run(60);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/conn_check_gen.md
Name: conn_check_gen

Overview:
- Parametrised successor of the fixed 8-output test-pattern generator in the connector checker top.
- N_CH channels each drive a square wave with a distinct period onto a connector pin.
- Each channel reads the looped-back pin, compares it with the driven level after a settle guard, and counts bad half-periods.
- Per-channel fail flags and counters feed LEDs and a readout mux.

Parameters:
- N_CH, 8, number of channels.
- BASE_T, 250000, base period in clk cycles; channel i period T_i = BASE_T*(i+1).
- CNT_W, 24, phase counter width; must hold N_CH*BASE_T-1.
- GUARD, 16, settle cycles after every drive edge before comparison starts; must be < BASE_T/2 - 1.
- ERR_W, 8, per-channel error counter width.

Ports:
- clk  in  1  system clock (1 MHz PLL output).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run generators and checking.
- clear  in  1  synchronous clear of error state; generators unaffected.
- loop_in  in  N_CH  looped-back connector inputs, asynchronous.
- err_sel  in  $clog2(N_CH)  selects the channel for err_cnt_sel.
- drive_out  out  N_CH  generated pattern to the connector.
- ch_fail  out  N_CH  sticky per-channel fail flag.
- err_cnt_sel  out  ERR_W  error counter of channel err_sel, registered.
- checked  out  1  every channel has evaluated >= 2 windows since enable rise or clear.
- stuck_hi, stuck_lo  out  N_CH  see Optional Feature.

Behaviour:
- Reset (async): all counters, synchronisers, drive_out, ch_fail, err_cnt_sel, checked, stuck_* = 0.
- Generator i:
  - phase_i counts 0..T_i-1 and wraps.
  - drive_out[i] is registered and = 1 while phase_i < T_i/2 (integer divide), else 0.
  - First high cycle is the cycle after enable is sampled 1.
- enable = 0:
  - phase held at 0, drive_out = 0, checking suspended, window state discarded.
  - ch_fail and counters hold.
  - Re-enable restarts every channel at phase 0, in phase with the others.
- Input path: loop_in[i] passes through a 2-flop synchroniser giving sync_i (2-cycle latency).
- Window = one half-period, high or low.
  - A guard counter loads GUARD on each drive_out[i] edge and counts down to 0.
  - Compare is active when enable = 1 and guard = 0.
  - Any compare cycle with sync_i != drive_out[i] sets a window-bad flag.
  - On the last cycle of the window (cycle before drive toggles), a bad window increments err_i once (saturates at 2^ERR_W-1) and sets ch_fail[i].
  - The window flag then resets. Every window counts as evaluated.
- clear:
  - zeroes err_i, ch_fail, checked, stuck_* and evaluated-window counts next cycle.
  - clear coincident with a window-end increment: clear wins, count = 0.
  - The current window's bad flag is also discarded.
- checked: set when all channels have >= 2 evaluated windows; stays set until clear, enable low, or reset.
- err_cnt_sel: registered mux, 1-cycle latency from err_sel or err_i change. err_sel >= N_CH returns 0.
- Reset mid-window: everything returns to reset values immediately; no partial increment.

Optional Feature:
- Macro: CONN_CHK_STUCK_EN.
- Defined:
  - per channel, track whether sync_i stayed 1 (or 0) for every compare cycle of a bad window.
  - Such a window sets sticky stuck_hi[i] (or stuck_lo[i]).
  - Cleared by clear or reset.
- Undefined: stuck_hi and stuck_lo are constant 0 and the tracking logic is absent. ch_fail and err counting are unchanged.

Test Plan:
- Bench params N_CH=4, BASE_T=40, GUARD=4.
- Reset, enable=1, loop_in=drive_out delayed 1 cycle -> drive_out[0] period 40 (20 high/20 low), [3] period 160; ch_fail=0, err=0; checked=1 after ch3 finishes 2 windows (cycle ~161).
- Loopback with ch1 pin held 0 -> ch1 high windows bad: err_cnt_sel (err_sel=1) = 1, 2, 3 at each 40-cycle high-window end; ch_fail=4'b0010; stuck_lo[1]=1 if CONN_CHK_STUCK_EN.
- Loopback with a 3-cycle-wide inverted glitch on ch0, 2 cycles after an edge (inside guard) -> no error; same glitch at cycle 10 of the window -> err0 += 1 exactly once.
- Force ch2 mismatch for 300 windows with ERR_W=8 -> counter saturates at 255; clear asserted on an increment cycle -> err2=0, ch_fail[2]=0, checked=0.
- Drop enable mid-period -> drive_out=0 next cycle, counters hold; re-enable -> all channels rise together; assert reset_n=0 mid-window -> all outputs 0 asynchronously.
